// File: rtl/phase_clkgen_if.sv
// Run/configuration bundle and generated clock outputs for phase_clkgen.
// Driven by a controller (master) and consumed by the generator (slave).
interface phase_clkgen_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8
);
  logic                run;
  logic                cfg_we;
  logic [3:0]          cfg_addr;
  logic                cfg_en;
  logic [DIV_W-1:0]    cfg_half;
  logic [DIV_W-1:0]    cfg_delay;
  logic [CHANNELS-1:0] out;
  logic                locked;

  modport master (
    output run, cfg_we, cfg_addr, cfg_en, cfg_half, cfg_delay,
    input  out, locked
  );

  modport slave (
    input  run, cfg_we, cfg_addr, cfg_en, cfg_half, cfg_delay,
    output out, locked
  );
endinterface

// File: rtl/phase_clkgen.sv
// Multi-channel programmable clock generator with per-channel start delay.
// Outputs and locked are registered (one edge after the deciding state); no backpressure.
module phase_clkgen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  phase_clkgen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } ch_state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  // Stored configuration
  logic [CHANNELS-1:0] en_q;
  logic [DIV_W-1:0]    half_q  [CHANNELS];
  logic [DIV_W-1:0]    delay_q [CHANNELS];

  // Channel state
  ch_state_t           state_q [CHANNELS];
  ch_state_t           state_d [CHANNELS];
  logic [DIV_W-1:0]    cnt_q   [CHANNELS];
  logic [DIV_W-1:0]    cnt_d   [CHANNELS];
  logic [DIV_W-1:0]    hact_q  [CHANNELS];
  logic [DIV_W-1:0]    hact_d  [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;

  logic run_q;
  logic locked_q;
  logic locked_d;
  logic start;
  logic any_en;
  logic all_run;

  // Writes to addresses beyond the last channel simply match no channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        half_q[i]  <= '0;
        delay_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.cfg_we && (bus.cfg_addr == 4'(i))) begin
          en_q[i]    <= bus.cfg_en;
          half_q[i]  <= bus.cfg_half;
          delay_q[i] <= bus.cfg_delay;
        end
      end
    end
  end

  always_comb begin
    start    = bus.run && !run_q;
    any_en   = 1'b0;
    all_run  = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en_q[i]) begin
        any_en = 1'b1;
        if (state_q[i] != RUN) begin
          all_run = 1'b0;
        end
      end
    end
    locked_d = bus.run && run_q && any_en && all_run;

    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hact_d[i]  = hact_q[i];
      out_d[i]   = out_q[i];

      if (!bus.run) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
      end else if (start) begin
        // Start uses the configuration stored before this edge.
        out_d[i] = 1'b0;
        if (en_q[i]) begin
          state_d[i] = DELAY;
          cnt_d[i]   = delay_q[i];
          hact_d[i]  = half_q[i];
        end else begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      end else if (!en_q[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
      end else begin
        case (state_q[i])
          DELAY: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
              out_d[i]   = 1'b1;
              cnt_d[i]   = hact_q[i];
              state_d[i] = RUN;
            end
          end
          RUN: begin
            // New half-period is picked up only at a toggle, so no runt pulse.
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
              out_d[i]  = ~out_q[i];
              hact_d[i] = half_q[i];
              cnt_d[i]  = half_q[i];
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      locked_q <= 1'b0;
      out_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        hact_q[i]  <= '0;
      end
    end else begin
      run_q    <= bus.run;
      locked_q <= locked_d;
      out_q    <= out_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hact_q[i]  <= hact_d[i];
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.locked = locked_q;

endmodule

// File: doc/phase_clkgen.md
PHASE_CLKGEN -- requirements
Module: phase_clkgen

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, the number of independent output channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, the width of the half-period and delay fields.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port run, input, 1, the level start/stop control.
REQ-006 The block SHALL have port cfg_we, input, 1, the configuration write strobe.
REQ-007 The block SHALL have port cfg_addr, input, 4, the target channel index.
REQ-008 The block SHALL have port cfg_en, input, 1, the channel enable value to write.
REQ-009 The block SHALL have port cfg_half, input, DIV_W, the half-period minus one, in clk cycles.
REQ-010 The block SHALL have port cfg_delay, input, DIV_W, the start delay in clk cycles.
REQ-011 The block SHALL have port out, output, CHANNELS, the generated clocks, registered.
REQ-012 The block SHALL have port locked, output, 1, high when all enabled channels are running; registered.

Function
REQ-013 When cfg_we=1 and cfg_addr<CHANNELS, the block SHALL store en/half/delay for that channel at the clk edge; a write with cfg_addr>=CHANNELS SHALL be ignored.
REQ-014 The block SHALL register run as run_q; a start event SHALL be run=1 && run_q=0.
REQ-015 Each channel SHALL have the states IDLE, DELAY and RUN, and SHALL hold a down-counter cnt (DIV_W bits) and an active half-period register.
REQ-016 On a start event, each enabled channel SHALL go IDLE->DELAY, with cnt=delay, active half=stored half and out=0; disabled channels SHALL stay IDLE.
REQ-017 In DELAY, a channel SHALL decrement cnt while cnt!=0; at cnt=0 it SHALL set out=1, load cnt=active half and go to RUN. The first out rise SHALL therefore occur delay+1 edges after the start edge.
REQ-018 In RUN, a channel SHALL decrement cnt while cnt!=0; at cnt=0 it SHALL toggle out, reload active half from stored half, and reload cnt with that value. The output period SHALL be 2*(half+1) cycles at 50% duty.
REQ-019 A channel with half=0 SHALL produce out toggling every edge (clk/2).
REQ-020 A half write during RUN SHALL take effect at the next toggle, with no runt pulse; a delay write during RUN SHALL take effect only at the next start event.
REQ-021 When cfg_we hits a channel on the same edge as a start event, the start SHALL use the previously stored values; the new values SHALL then apply per REQ-020.
REQ-022 When run=0 is sampled, all channels SHALL go to IDLE with out=0 and locked=0 at that edge, regardless of state.
REQ-023 Clearing en during DELAY/RUN SHALL force that channel to IDLE with out=0 at the next edge; setting en during run=1 SHALL NOT start the channel before the next start event.
REQ-024 locked SHALL be registered from (run_q && at least one channel enabled && every enabled channel in RUN); it SHALL be 0 if no channel is enabled.
REQ-025 Counters SHALL never wrap: cnt SHALL be reloaded at 0 and never decremented below 0.

Reset
REQ-026 While rst_n=0, out=0, locked=0, run_q=0, all channels IDLE, cnt=0, and stored en/half/delay=0, asserted asynchronously.
REQ-027 Release of rst_n with run already 1 SHALL be treated as a start event on the first edge after release (run_q=0).

Verification
REQ-028 Quadrature: all four channels enabled with half=1 and delays 0,1,2,3, then run 0->1 -> out[0..3] rise at start+1,+2,+3,+4 edges; each has period 4; locked=1 one edge after out[3] first rises.
REQ-029 Half change: ch0 half=3 running, write half=0 mid-high-phase -> the current high phase lasts 4 cycles, then out toggles every cycle; no pulse shorter than 1 cycle.
REQ-030 Stop/restart: run dropped mid-DELAY on ch2 (delay=10) -> all out=0 and locked=0 next edge; run reasserted -> ch2 rises exactly 11 edges later.
REQ-031 Disable mid-run: cfg_we to ch1 with en=0 -> out[1]=0 next edge; locked stays 1 if the other enabled channels are in RUN; re-enable -> out[1] stays 0 until run toggles.
REQ-032 Reset mid-operation: rst_n pulsed low between edges while running -> out=0 and locked=0 immediately; after release all configuration reads as disabled and no output toggles.
REQ-033 Boundaries: cfg_addr=15 write ignored with CHANNELS=4; half=255/delay=255 gives first rise at 256 edges and period 512; no channels enabled with run=1 -> locked stays 0.
